// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the four intersection light buses: decodes the active
// phase, tracks rotation order and dwell, and latches sticky violation flags.
module traffic_light_monitor #(
    parameter int GREEN_CYCLES  = 16,
    parameter int YELLOW_CYCLES = 4,
    parameter int DW            = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    north_light,
    input  logic [2:0]    west_light,
    input  logic [2:0]    south_light,
    input  logic [2:0]    east_light,
    input  logic          err_clr,
    output logic          phase_valid,
    output logic [1:0]    cur_dir,
    output logic          cur_yellow,
    output logic [DW-1:0] dwell,
    output logic          phase_change,
    output logic          cycle_done,
    output logic [4:0]    err_flags,
    output logic          err_any
);
    localparam logic [DW-1:0] GLIM = DW'(GREEN_CYCLES);
    localparam logic [DW-1:0] YLIM = DW'(YELLOW_CYCLES);
    localparam logic [DW-1:0] DMAX = '1;

    localparam int ENC = 0, CONFLICT = 1, IDLE = 2, SEQ = 3, TIMING = 4;

    logic [3:0][2:0] lights;
    assign lights = {east_light, south_light, west_light, north_light};

    // Sample decode
    logic       enc, conflict, idle;
    logic [2:0] nonred;
    logic [1:0] s_dir;
    logic       s_yel;

    always_comb begin
        enc    = 1'b0;
        nonred = 3'd0;
        s_dir  = 2'd0;
        s_yel  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (lights[i] != 3'b001 && lights[i] != 3'b010 && lights[i] != 3'b100)
                enc = 1'b1;
            if (lights[i] != 3'b100) begin
                nonred = nonred + 3'd1;
                s_dir  = 2'(i);
                s_yel  = (lights[i] == 3'b010);
            end
        end
    end

    assign conflict = (nonred >= 3'd2);
    assign idle     = (nonred == 3'd0);

    logic          synced, synced_n;
    logic          valid_n, pc_n, cd_n;
    logic [1:0]    dir_n, succ_dir;
    logic          yel_n, succ_yel;
    logic [DW-1:0] dwell_n, limit;
    logic [4:0]    viol, flags_n;

    // Legal successor of the held phase: green(d)->yellow(d), yellow(d)->green(d+1)
    assign succ_yel = ~cur_yellow;
    assign succ_dir = cur_yellow ? cur_dir + 2'd1 : cur_dir;
    assign limit    = cur_yellow ? YLIM : GLIM;

    always_comb begin
        viol     = 5'd0;
        valid_n  = 1'b0;
        pc_n     = 1'b0;
        cd_n     = 1'b0;
        synced_n = synced;
        dir_n    = cur_dir;
        yel_n    = cur_yellow;
        dwell_n  = dwell;
        viol[ENC]      = enc;
        viol[CONFLICT] = conflict;
        viol[IDLE]     = idle;
        if (enc || conflict || idle) begin
            synced_n = 1'b0;
        end else begin
            valid_n = 1'b1;
            if (s_dir == cur_dir && s_yel == cur_yellow) begin
                // Flag only the crossing sample so a long overstay reports once
                if (dwell == limit) viol[TIMING] = 1'b1;
                if (dwell != DMAX) dwell_n = dwell + 1'b1;
            end else begin
                if (synced) begin
                    if (s_dir != succ_dir || s_yel != succ_yel) viol[SEQ] = 1'b1;
                    if (dwell != limit) viol[TIMING] = 1'b1;
                    cd_n = cur_yellow && cur_dir == 2'd3 && !s_yel && s_dir == 2'd0;
                end
                synced_n = 1'b1;
                dir_n    = s_dir;
                yel_n    = s_yel;
                dwell_n  = DW'(1);
                pc_n     = 1'b1;
            end
        end
        flags_n = (err_clr ? 5'd0 : err_flags) | viol;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_valid  <= 1'b0;
            cur_dir      <= 2'd0;
            cur_yellow   <= 1'b0;
            dwell        <= '0;
            phase_change <= 1'b0;
            cycle_done   <= 1'b0;
            err_flags    <= 5'd0;
            err_any      <= 1'b0;
            synced       <= 1'b1;
        end else begin
            phase_valid  <= valid_n;
            cur_dir      <= dir_n;
            cur_yellow   <= yel_n;
            dwell        <= dwell_n;
            phase_change <= pc_n;
            cycle_done   <= cd_n;
            err_flags    <= flags_n;
            err_any      <= |flags_n;
            synced       <= synced_n;
        end
    end
endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: a phase-index model (0..7 = dir*2+yellow)
// predicts every output each cycle, plus literal expectations for key scenarios.
module tb_traffic_light_monitor;
    localparam int G = 16, Y = 4, DW = 5;
    localparam int DSAT = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    nl, wl, sl, el;
    logic          err_clr;
    logic          phase_valid, cur_yellow, phase_change, cycle_done, err_any;
    logic [1:0]    cur_dir;
    logic [DW-1:0] dwell;
    logic [4:0]    err_flags;

    traffic_light_monitor #(.GREEN_CYCLES(G), .YELLOW_CYCLES(Y), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .north_light(nl), .west_light(wl), .south_light(sl), .east_light(el),
        .err_clr(err_clr),
        .phase_valid(phase_valid), .cur_dir(cur_dir), .cur_yellow(cur_yellow),
        .dwell(dwell), .phase_change(phase_change), .cycle_done(cycle_done),
        .err_flags(err_flags), .err_any(err_any)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Model state: phase index, dwell count, sync flag, sticky flags, pulse expectations
    int       m_p, m_dw;
    bit       m_sync, e_valid, e_pc, e_cd;
    bit [4:0] m_flags;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lim(input int p);
        return (p % 2) ? Y : G;
    endfunction

    function automatic logic [2:0] code_of(input int p, input int d);
        if (d != p / 2) return 3'b100;
        return (p % 2) ? 3'b010 : 3'b001;
    endfunction

    task automatic model_reset();
        m_p = 0; m_dw = 0; m_sync = 1; m_flags = 0;
        e_valid = 0; e_pc = 0; e_cd = 0;
    endtask

    task automatic model_step(input logic [2:0] n, w, s, e, input bit clr);
        logic [2:0] l [4];
        bit enc;
        int nr, np;
        bit [4:0] v;
        l[0] = n; l[1] = w; l[2] = s; l[3] = e;
        enc = 0; nr = 0; np = 0; v = 0;
        e_pc = 0; e_cd = 0;
        for (int i = 0; i < 4; i++) begin
            if (!(l[i] inside {3'b001, 3'b010, 3'b100})) enc = 1;
            if (l[i] != 3'b100) begin
                nr++;
                np = i * 2 + ((l[i] == 3'b010) ? 1 : 0);
            end
        end
        v[0] = enc; v[1] = (nr >= 2); v[2] = (nr == 0);
        if (v[2:0] != 0) begin
            e_valid = 0;
            m_sync = 0;
        end else begin
            e_valid = 1;
            if (np == m_p) begin
                if (m_dw == lim(m_p)) v[4] = 1;
                if (m_dw < DSAT) m_dw++;
            end else begin
                if (m_sync) begin
                    if (np != (m_p + 1) % 8) v[3] = 1;
                    if (m_dw != lim(m_p)) v[4] = 1;
                    e_cd = (m_p == 7 && np == 0);
                end
                m_sync = 1;
                m_p = np;
                m_dw = 1;
                e_pc = 1;
            end
        end
        m_flags = (clr ? 5'd0 : m_flags) | v;
    endtask

    task automatic compare_all();
        chk("phase_valid", 32'(phase_valid), 32'(e_valid));
        chk("cur_dir", 32'(cur_dir), 32'(m_p / 2));
        chk("cur_yellow", 32'(cur_yellow), 32'(m_p % 2));
        chk("dwell", 32'(dwell), 32'(m_dw));
        chk("phase_change", 32'(phase_change), 32'(e_pc));
        chk("cycle_done", 32'(cycle_done), 32'(e_cd));
        chk("err_flags", 32'(err_flags), 32'(m_flags));
        chk("err_any", 32'(err_any), 32'(|m_flags));
    endtask

    // Called at a negedge; returns at the following negedge
    task automatic drive(input logic [2:0] n, w, s, e, input bit clr);
        nl = n; wl = w; sl = s; el = e; err_clr = clr;
        model_step(n, w, s, e, clr);
        @(posedge clk); #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic ph(input int p, input int cnt);
        repeat (cnt) drive(code_of(p, 0), code_of(p, 1), code_of(p, 2), code_of(p, 3), 1'b0);
    endtask

    task automatic do_rst();
        rst = 1'b1; err_clr = 1'b0;
        model_reset();
        #1 compare_all();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int pc_cnt, cd_cnt, cd_a, cd_b, gmax, ymax;

    initial begin
        rst = 1'b1; err_clr = 1'b0;
        nl = 3'b100; wl = 3'b100; sl = 3'b100; el = 3'b100;
        @(negedge clk);
        do_rst();

        // Normal rotation, 200 samples from reset release
        pc_cnt = 0; cd_cnt = 0; cd_a = -1; cd_b = -1; gmax = 0; ymax = 0;
        for (int k = 0; k < 200; k++) begin
            int pos, p;
            pos = k % 80;
            p = (pos / 20) * 2 + (((pos % 20) >= 16) ? 1 : 0);
            ph(p, 1);
            if (phase_change) pc_cnt++;
            if (cycle_done) begin
                cd_cnt++;
                if (cd_a < 0) cd_a = k + 1; else cd_b = k + 1;
            end
            if (!cur_yellow && int'(dwell) > gmax) gmax = int'(dwell);
            if (cur_yellow && int'(dwell) > ymax) ymax = int'(dwell);
        end
        chk("run_flags", 32'(err_flags), 32'd0);
        chk("run_pc_count", 32'(pc_cnt), 32'd19);
        chk("run_cd_count", 32'(cd_cnt), 32'd2);
        chk("run_cd_first", 32'(cd_a), 32'd81);
        chk("run_cd_second", 32'(cd_b), 32'd161);
        chk("run_green_peak", 32'(gmax), 32'd16);
        chk("run_yellow_peak", 32'(ymax), 32'd4);

        // Illegal code mid N-green, then a normal rotation must stay clean
        do_rst();
        ph(0, 5);
        drive(3'b011, 3'b100, 3'b100, 3'b100, 1'b0);
        chk("enc_flag", 32'(err_flags), 32'b00001);
        chk("enc_invalid", 32'(phase_valid), 32'd0);
        ph(0, 10); ph(1, 4); ph(2, 16); ph(3, 4); ph(4, 3);
        chk("enc_no_followon", 32'(err_flags), 32'b00001);

        // Clear with no violation present
        drive(3'b100, 3'b100, 3'b001, 3'b100, 1'b1);
        chk("clr_plain", 32'(err_flags), 32'd0);

        // Conflicting greens, then all red
        drive(3'b001, 3'b001, 3'b100, 3'b100, 1'b0);
        chk("conflict", 32'(err_flags), 32'b00010);
        drive(3'b100, 3'b100, 3'b100, 3'b100, 1'b0);
        chk("idle", 32'(err_flags), 32'b00110);

        // Sequence skip N-yellow -> S-green
        do_rst();
        ph(0, 16); ph(1, 4); ph(4, 1);
        chk("seq_flag", 32'(err_flags), 32'b01000);
        chk("seq_dir", 32'(cur_dir), 32'd2);

        // Green overstay: one flag on the 17th sample, dwell saturates later
        do_rst();
        ph(0, 16);
        chk("over_16", 32'(err_flags), 32'd0);
        ph(0, 1);
        chk("over_17", 32'(err_flags), 32'b10000);
        drive(3'b001, 3'b100, 3'b100, 3'b100, 1'b1);
        chk("over_once", 32'(err_flags), 32'd0);
        ph(0, 20);
        chk("dwell_sat", 32'(dwell), 32'(DSAT));

        // Short yellow reported at the W-green sample
        do_rst();
        ph(0, 16); ph(1, 3);
        chk("short_pre", 32'(err_flags), 32'd0);
        ph(2, 1);
        chk("short_yellow", 32'(err_flags), 32'b10000);

        // Clear colliding with ENC: ENC wins, TIMING is cleared
        drive(3'b011, 3'b100, 3'b100, 3'b100, 1'b1);
        chk("clr_vs_enc", 32'(err_flags), 32'b00001);

        // First sample after reset not N-green
        do_rst();
        ph(2, 1);
        chk("first_wg", 32'(err_flags), 32'b11000);
        do_rst();
        ph(1, 1);
        chk("first_ny", 32'(err_flags), 32'b10000);

        // Reset mid W-green, then a fresh N-green
        do_rst();
        ph(0, 16); ph(1, 4); ph(2, 5);
        do_rst();
        chk("rst_dir", 32'(cur_dir), 32'd0);
        ph(0, 1);
        chk("rst_restart_dwell", 32'(dwell), 32'd1);
        chk("rst_restart_flags", 32'(err_flags), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Receive-side checker for the four 3-bit light buses driven by the intersection controller.
- Decodes each sampled light pattern into the active direction and phase, and tracks rotation order and phase dwell times.
- Raises sticky violation flags for illegal codes, conflicting greens, all-red, out-of-order phases and wrong dwell.
- Sits beside the controller, both in silicon, where it drives a safety interlock, and in simulation.

Parameters:
GREEN_CYCLES, 16, required number of consecutive samples for a green phase
YELLOW_CYCLES, 4, required number of consecutive samples for a yellow phase
DW, 5, dwell counter width; must satisfy GREEN_CYCLES <= 2^DW-2

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
north_light  in  3  light code: 001 green, 010 yellow, 100 red
west_light  in  3  same encoding
south_light  in  3  same encoding
east_light  in  3  same encoding
err_clr  in  1  synchronous clear of err_flags
phase_valid  out  1  last sample was legal (exactly one non-red light, all codes legal)
cur_dir  out  2  active direction: 0 N, 1 W, 2 S, 3 E
cur_yellow  out  1  0 green, 1 yellow
dwell  out  DW  consecutive samples of the current phase, saturating at 2^DW-1
phase_change  out  1  one-cycle pulse on an accepted phase transition
cycle_done  out  1  one-cycle pulse on the E-yellow to N-green transition
err_flags  out  5  sticky: [0] ENC, [1] CONFLICT, [2] IDLE, [3] SEQ, [4] TIMING
err_any  out  1  OR of err_flags

Behaviour:
- All outputs are registered and sampled on the rising edge of clk. Latency is 1 cycle from light inputs to outputs.
- Reset values:
  - phase_valid=0, cur_dir=0, cur_yellow=0, dwell=0, phase_change=0, cycle_done=0, err_flags=0.
  - Internal synced=1, so the monitor expects the N-green start.
- Per-sample decode:
  - Any light not in {001,010,100}: set ENC.
  - Two or more non-red lights: set CONFLICT.
  - All four red: set IDLE.
  - Any of these makes the sample invalid: phase_valid=0, synced cleared, cur_dir/cur_yellow/dwell hold.
- Valid sample with phase equal to the current phase:
  - dwell increments, saturating.
  - Set TIMING on the first sample where dwell would exceed the limit (GREEN_CYCLES or YELLOW_CYCLES). Flag once per phase; later samples do not re-flag.
- Valid sample with a different phase:
  - Legal successor: green(d) -> yellow(d); yellow(d) -> green(d+1 mod 4), order N,W,S,E,N.
  - If synced=1:
    - Set SEQ if the new phase is not the legal successor.
    - Set TIMING if the outgoing dwell != its limit.
  - If synced=0: skip both checks and set synced=1 (resynchronisation; the first phase after an invalid sample is never short-checked).
  - Load the new phase, set dwell=1, pulse phase_change.
  - Pulse cycle_done only on a legal E-yellow -> N-green transition with synced=1 before the transition.
- First sample after reset:
  - N-green gives dwell=1.
  - Any other valid phase is treated as an exit from N-green with dwell 0, which sets TIMING, plus SEQ if that phase is not N-yellow.
- err_flags:
  - Sticky.
  - err_clr clears all flags.
  - A violation in the same cycle as err_clr wins: that flag is set.
- Reset mid-operation returns immediately to the reset values. The monitor and controller are expected to share rst.
- Dwell counting has no wrap-around; it saturates.

Test Plan:
- Normal run: share rst with the controller, run 200 cycles.
  - err_flags stays 00000.
  - phase_change fires every 16/4 samples.
  - cycle_done pulses at cycles 81 and 161 after reset release.
  - dwell peaks at 16 and at 4.
- Illegal code: force north_light=011 for 1 cycle during N-green.
  - err_flags[0]=1 and phase_valid=0 the next cycle.
  - After the pattern is restored, no SEQ/TIMING is raised on the following transition.
- Conflict and idle:
  - Drive N=001 and W=001 -> err_flags[1]=1.
  - Drive all four 100 -> err_flags[2]=1.
- Sequence skip: N-green 16 samples, N-yellow 4, then S-green.
  - err_flags[3]=1; cur_dir=2 the next cycle.
- Timing:
  - Hold N-green for 17 samples -> err_flags[4] sets on the 17th sample, once.
  - Separately, N-yellow for only 3 samples -> err_flags[4] sets at the W-green sample.
- Clear and reset:
  - Assert err_clr with no violation -> flags return to 0.
  - Assert err_clr in the same cycle as an ENC violation -> err_flags[0] stays 1.
  - Assert rst mid-W-green -> all outputs return to reset values; the next N-green starts with dwell=1.
